c64_debug_master: RTL
=====================

C64_DEBUG_MASTER -- requirements
Module: c64_debug_master

Interface
REQ-001 Parameter TIMEOUT, default 1000000, is the number of clk cycles to wait for a response byte before aborting; range 1..2^24-1.
REQ-002 Parameter ACK_BYTE, default 8'h06, is the response byte that confirms a write.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1 bit: command request, sampled when cmd_ready=1.
REQ-006 Port cmd_ready, output, 1 bit: block is idle and will accept a command this cycle.
REQ-007 Port cmd_write, input, 1 bit: 1 selects write, 0 selects read.
REQ-008 Port cmd_addr, input, 16 bits: target address.
REQ-009 Port cmd_wdata, input, 8 bits: write data; ignored for reads.
REQ-010 Port uart_tx_byte_valid, output, 1 bit: uart_tx_byte is presented to the UART transmitter.
REQ-011 Port uart_tx_byte, output, 8 bits: byte to transmit.
REQ-012 Port uart_tx_ready, input, 1 bit: the transmitter accepts the byte this cycle.
REQ-013 Port uart_rx_byte_valid, input, 1 bit: one-cycle strobe for a received byte.
REQ-014 Port uart_rx_byte, input, 8 bits: received byte.
REQ-015 Port rsp_valid, output, 1 bit: one-cycle strobe that completes a command.
REQ-016 Port rsp_data, output, 8 bits: read data, or the raw write-acknowledge byte.
REQ-017 Port rsp_error, output, 1 bit: the command failed (timeout, or wrong write acknowledge).

Function
REQ-018 The state machine SHALL have the states IDLE, SEND_OP, SEND_AH, SEND_AL, SEND_DATA and WAIT_RSP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, cmd_write/cmd_addr/cmd_wdata SHALL be latched and the state SHALL go to SEND_OP on the next cycle.
REQ-020 In each SEND_* state, uart_tx_byte_valid SHALL be 1 with a stable byte until the cycle where uart_tx_ready=1, then advance; byte values: SEND_OP = 8'h02 (write) or 8'h01 (read), SEND_AH = addr[15:8], SEND_AL = addr[7:0], SEND_DATA = wdata.
REQ-021 Transitions: SEND_OP->SEND_AH->SEND_AL; SEND_AL->SEND_DATA for writes, SEND_AL->WAIT_RSP for reads; SEND_DATA->WAIT_RSP.
REQ-022 uart_tx_byte_valid SHALL be 0 in IDLE and WAIT_RSP; a byte is transferred exactly once per valid&&ready cycle, and back-to-back bytes on consecutive cycles are allowed.
REQ-023 A 24-bit timeout counter SHALL clear on entry to WAIT_RSP and increment once per cycle while in WAIT_RSP.
REQ-024 In WAIT_RSP, on uart_rx_byte_valid: rsp_valid=1 for one cycle, rsp_data=uart_rx_byte, rsp_error = (write && byte!=ACK_BYTE), then next state IDLE.
REQ-025 In WAIT_RSP, if the counter reaches TIMEOUT without a received byte: rsp_valid=1, rsp_data=8'h00, rsp_error=1, then next state IDLE.
REQ-026 If uart_rx_byte_valid arrives in the same cycle the counter reaches TIMEOUT, the received byte SHALL win.
REQ-027 uart_rx_byte_valid outside WAIT_RSP (stray or late bytes) SHALL be ignored; this includes bytes arriving during SEND_*.
REQ-028 rsp_data and rsp_error SHALL hold their last values between strobes.
REQ-029 Latency: command accepted in cycle N, so the first uart_tx_byte_valid is in cycle N+1; response byte strobed in cycle M gives rsp_valid in cycle M+1, and cmd_ready=1 in cycle M+2.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, cmd_ready=0 (1 after release), uart_tx_byte_valid=0, uart_tx_byte=0, rsp_valid=0, rsp_data=0, rsp_error=0, counter=0, latched command cleared.
REQ-031 Reset asserted mid-command SHALL abort it with no rsp_valid; a response byte arriving after release SHALL be ignored per REQ-027.

Verification
REQ-032 Read with cmd_addr=16'hD020 and uart_tx_ready tied 1 -> tx bytes 01,D0,20 on consecutive cycles; rx 8'h0E -> rsp_valid, rsp_data=0E, rsp_error=0.
REQ-033 Write with addr=16'h0400, wdata=8'h41, ready low 3 cycles per byte -> tx bytes 02,04,00,41, each held stable until ready=1; rx 06 -> rsp_error=0, rsp_data=06.
REQ-034 Write answered with rx 8'h15 -> rsp_valid, rsp_data=15, rsp_error=1.
REQ-035 Read with TIMEOUT=16 and no rx byte -> rsp_valid exactly 16 cycles after entering WAIT_RSP, rsp_data=00, rsp_error=1; a later rx byte is ignored.
REQ-036 Simultaneous rx strobe and timeout -> rsp_error=0 for a read, rsp_data = the received byte.
REQ-037 Reset pulsed during SEND_AH -> outputs at reset values immediately, no rsp_valid, cmd_ready=1 one cycle after release; a new read then completes normally.

Source files
------------

// File: rtl/c64_debug_master.sv
// c64_debug_master: turns a read/write command into a byte sequence on a UART
// transmitter (opcode, address high, address low, optional data), then waits
// for a single response byte, or aborts with an error after TIMEOUT cycles.
module c64_debug_master #(
    parameter int unsigned TIMEOUT  = 1000000,
    parameter logic [7:0]  ACK_BYTE = 8'h06
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        uart_tx_byte_valid,
    output logic [7:0]  uart_tx_byte,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_byte_valid,
    input  logic [7:0]  uart_rx_byte,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_error
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND_OP   = 3'd1;
    localparam logic [2:0] SEND_AH   = 3'd2;
    localparam logic [2:0] SEND_AL   = 3'd3;
    localparam logic [2:0] SEND_DATA = 3'd4;
    localparam logic [2:0] WAIT_RSP  = 3'd5;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    // The counter starts at 0 on the first WAIT_RSP cycle; when it shows
    // TIMEOUT-1 it is about to reach TIMEOUT, so the abort is registered then
    // and rsp_valid appears exactly TIMEOUT cycles after entry.
    localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [23:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_error_q, rsp_error_d;
    logic        rdy_q;

    // Command handshake: idle, out of reset for at least one edge, and not in
    // the response-strobe cycle (keeps cmd_ready low for one cycle after rsp).
    assign cmd_ready = (state_q == IDLE) && rdy_q && !rsp_valid_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;

    // Transmit byte selection, driven directly from the current state.
    always_comb begin
        uart_tx_byte_valid = 1'b0;
        uart_tx_byte       = 8'h00;
        case (state_q)
            SEND_OP: begin
                uart_tx_byte_valid = 1'b1;
                uart_tx_byte       = write_q ? OP_WRITE : OP_READ;
            end
            SEND_AH: begin
                uart_tx_byte_valid = 1'b1;
                uart_tx_byte       = addr_q[15:8];
            end
            SEND_AL: begin
                uart_tx_byte_valid = 1'b1;
                uart_tx_byte       = addr_q[7:0];
            end
            SEND_DATA: begin
                uart_tx_byte_valid = 1'b1;
                uart_tx_byte       = wdata_q;
            end
            default: begin
                uart_tx_byte_valid = 1'b0;
                uart_tx_byte       = 8'h00;
            end
        endcase
    end

    // Next-state logic: command latch, byte sequencing, response/timeout.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = SEND_OP;
                end
            end
            SEND_OP: begin
                if (uart_tx_ready) state_d = SEND_AH;
            end
            SEND_AH: begin
                if (uart_tx_ready) state_d = SEND_AL;
            end
            SEND_AL: begin
                if (uart_tx_ready) begin
                    if (write_q) begin
                        state_d = SEND_DATA;
                    end else begin
                        state_d = WAIT_RSP;
                        cnt_d   = 24'd0;
                    end
                end
            end
            SEND_DATA: begin
                if (uart_tx_ready) begin
                    state_d = WAIT_RSP;
                    cnt_d   = 24'd0;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + 24'd1;
                // A received byte takes priority over a coincident timeout.
                if (uart_rx_byte_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = uart_rx_byte;
                    rsp_error_d = write_q && (uart_rx_byte != ACK_BYTE);
                    state_d     = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            cnt_q       <= 24'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            rdy_q       <= 1'b1;
        end
    end

endmodule
